// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants and types for the MEM-stage load/store unit.
//   - funct3 access-size encodings (F3_*)
//   - RV32I load/store major opcodes (OP_*)
//   - controller state enum
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   Request side (live MEM-stage inputs):
//     req_funct3, req_off, req_store, wdata -> be, wdata_rep, fault
//   Response side (latched request info):
//     ld_funct3, ld_off, rdata              -> ld_data (extended)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_off,
  input  logic        req_store,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        fault,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] lane;

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    fault     = 1'b0;
    case (req_funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << req_off;
        wdata_rep = {4{wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        be        = 4'b0011 << req_off;
        wdata_rep = {2{wdata[15:0]}};
        fault     = req_off[0];
      end
      F3_W: begin
        be    = 4'b1111;
        fault = (req_off != 2'b00);
      end
      default: fault = 1'b1;
    endcase
    // Unsigned sizes only exist for loads.
    if (req_store && req_funct3[2]) fault = 1'b1;
  end

  // Shift the addressed byte/half down to bit 0 before extending.
  always_comb begin
    lane = rdata >> {ld_off, 3'b000};
    case (ld_funct3)
      F3_B:    ld_data = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   ld_data = {24'd0, lane[7:0]};
      F3_H:    ld_data = {{16{lane[15]}}, lane[15:0]};
      F3_HU:   ld_data = {16'd0, lane[15:0]};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage load/store controller for an RV32I pipeline.
//   Accepts a decoded load/store (load_en, store_en, funct3, rd, addr, wdata),
//   runs a req/gnt/rvalid transaction on the data-memory port, stalls the
//   pipeline while the access is outstanding, and returns extended load data
//   on wb_valid/wb_rd/wb_data. Misaligned/illegal accesses raise addr_fault
//   combinationally; accesses exceeding TIMEOUT_CYCLES raise timeout_fault.
//   Ports: clk, rst_n (sync, active-low); pipeline side load_en, store_en,
//   funct3, rd, addr, wdata, stall, wb_*, addr_fault, timeout_fault; memory
//   side mem_req, mem_we, mem_be, mem_addr, mem_wdata, mem_gnt, mem_rvalid,
//   mem_rdata.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic        store_en,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        addr_fault,
  output logic        timeout_fault
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              timeout_fault_q, timeout_fault_d;
  logic [4:0]        rd_q, rd_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;

  logic              access, acc_fault, done, expire;
  logic [3:0]        be_new;
  logic [31:0]       wdata_new, ld_data;

  // A simultaneous load_en/store_en is handled as a store.
  assign access = load_en | store_en;

  lsu_align u_align (
    .req_funct3 (funct3),
    .req_off    (addr[1:0]),
    .req_store  (store_en),
    .wdata      (wdata),
    .be         (be_new),
    .wdata_rep  (wdata_new),
    .fault      (acc_fault),
    .ld_funct3  (funct3_q),
    .ld_off     (off_q),
    .rdata      (mem_rdata),
    .ld_data    (ld_data)
  );

  // In REQ a response only counts together with the grant.
  assign done   = ((state_q == REQ) && mem_gnt && mem_rvalid) ||
                  ((state_q == WAIT) && mem_rvalid);
  assign expire = (cnt_q == CNT_LAST);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_be_d        = mem_be_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    wb_valid_d      = 1'b0;
    wb_rd_d         = wb_rd_q;
    wb_data_d       = wb_data_q;
    timeout_fault_d = 1'b0;
    rd_d            = rd_q;
    funct3_d        = funct3_q;
    off_d           = off_q;
    stall           = 1'b0;
    addr_fault      = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (acc_fault) begin
            addr_fault = 1'b1;
          end else begin
            stall       = 1'b1;
            state_d     = REQ;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = store_en;
            mem_be_d    = be_new;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wdata_d = wdata_new;
            rd_d        = rd;
            funct3_d    = funct3;
            off_d       = addr[1:0];
          end
        end
      end
      REQ, WAIT: begin
        if (done) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = ld_data;
          end
        end else if (expire) begin
          state_d         = IDLE;
          mem_req_d       = 1'b0;
          timeout_fault_d = 1'b1;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if ((state_q == REQ) && mem_gnt) begin
            mem_req_d = 1'b0;
            state_d   = WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_be_q        <= 4'b0000;
      mem_addr_q      <= 32'd0;
      mem_wdata_q     <= 32'd0;
      wb_valid_q      <= 1'b0;
      wb_rd_q         <= 5'd0;
      wb_data_q       <= 32'd0;
      timeout_fault_q <= 1'b0;
      rd_q            <= 5'd0;
      funct3_q        <= 3'd0;
      off_q           <= 2'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_be_q        <= mem_be_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      wb_valid_q      <= wb_valid_d;
      wb_rd_q         <= wb_rd_d;
      wb_data_q       <= wb_data_d;
      timeout_fault_q <= timeout_fault_d;
      rd_q            <= rd_d;
      funct3_q        <= funct3_d;
      off_q           <= off_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_be        = mem_be_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign timeout_fault = timeout_fault_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed plus randomized bench for lsu_mem_ctrl with
// TIMEOUT_CYCLES=8; expectations come from a size/offset arithmetic model.
module tb_lsu_mem_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_en = 1'b0, store_en = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [4:0]  rd = 5'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        stall, wb_valid, addr_fault, timeout_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .store_en(store_en),
    .funct3(funct3), .rd(rd), .addr(addr), .wdata(wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .addr_fault(addr_fault), .timeout_fault(timeout_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    load_en = 1'b0; store_en = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  // Access size in bytes; 0 marks an undefined funct3.
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: size_of = 1;
      3'd1, 3'd5: size_of = 2;
      3'd2:       size_of = 4;
      default:    size_of = 0;
    endcase
  endfunction

  function automatic bit legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = size_of(f3);
    legal = (sz != 0) && ((a % sz) == 0) && !(st && f3 >= 3'd4);
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdat);
    int sz;
    logic [31:0] mask, v;
    sz   = size_of(f3);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v    = (rdat >> (8 * (a % 4))) & mask;
    if (f3 < 3'd4 && v[8 * sz - 1]) v = v | ~mask;
    exp_load = v;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (size_of(f3))
      1:       exp_wdata = (wd & 32'hFF) * 32'h0101_0101;
      2:       exp_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
      default: exp_wdata = wd;
    endcase
  endfunction

  // One access: g = REQ/WAIT cycle index of the grant, rv = index of rvalid
  // (rv >= g); rv >= TO means the response never arrives in time.
  task automatic access(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r_d,
                        input int g, input int rv, input logic [31:0] rdat, input string nm);
    bit ok;
    bit wb_exp;
    int last;
    ok     = legal(st, f3, a);
    wb_exp = ld && !st && (rv < TO);
    last   = (rv < TO) ? rv : TO - 1;
    load_en = ld; store_en = st; funct3 = f3; addr = a; wdata = wd; rd = r_d;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    chk({nm, ":addr_fault"}, addr_fault, !ok);
    chk({nm, ":stall_accept"}, stall, ok);
    next_cycle();
    if (!ok) begin
      idle_in();
      @(negedge clk);
      chk({nm, ":no_req"}, mem_req, 0);
      chk({nm, ":no_wb"}, wb_valid, 0);
      next_cycle();
    end else begin
      for (int i = 0; i <= last; i++) begin
        mem_gnt    = (i == g);
        mem_rvalid = (i == rv);
        mem_rdata  = (i == rv) ? rdat : $urandom;
        @(negedge clk);
        chk({nm, ":mem_req"}, mem_req, (i <= g));
        chk({nm, ":stall_busy"}, stall, (i != last));
        if (i == 0) begin
          chk({nm, ":mem_we"}, mem_we, st);
          chk({nm, ":mem_be"}, mem_be, ((32'd1 << size_of(f3)) - 32'd1) << (a % 4));
          chk({nm, ":mem_addr"}, mem_addr, a & ~32'd3);
          if (st) chk({nm, ":mem_wdata"}, mem_wdata, exp_wdata(f3, wd));
        end
        next_cycle();
      end
      idle_in();
      if (rv >= TO) mem_rvalid = 1'b1;
      mem_rdata = $urandom;
      @(negedge clk);
      chk({nm, ":req_done"}, mem_req, 0);
      chk({nm, ":stall_done"}, stall, 0);
      chk({nm, ":wb_valid"}, wb_valid, wb_exp);
      chk({nm, ":timeout"}, timeout_fault, (rv >= TO));
      if (wb_exp) begin
        chk({nm, ":wb_rd"}, wb_rd, r_d);
        chk({nm, ":wb_data"}, wb_data, exp_load(f3, a, rdat));
      end
      next_cycle();
      mem_rvalid = 1'b0;
      @(negedge clk);
      chk({nm, ":wb_pulse"}, wb_valid, 0);
      chk({nm, ":to_pulse"}, timeout_fault, 0);
      next_cycle();
    end
  endtask

  int          kind, g, rv;
  logic [2:0]  rf3;
  logic [31:0] ra;

  initial begin
    rst_n = 1'b0;
    idle_in();
    repeat (2) next_cycle();
    @(negedge clk);
    chk("rst:mem_req", mem_req, 0);
    chk("rst:mem_we", mem_we, 0);
    chk("rst:mem_be", mem_be, 0);
    chk("rst:mem_addr", mem_addr, 0);
    chk("rst:mem_wdata", mem_wdata, 0);
    chk("rst:wb_valid", wb_valid, 0);
    chk("rst:wb_rd", wb_rd, 0);
    chk("rst:wb_data", wb_data, 0);
    chk("rst:timeout", timeout_fault, 0);
    chk("rst:stall", stall, 0);
    next_cycle();
    rst_n = 1'b1;

    access(1, 0, 3'b010, 32'h100, 32'd0, 5'd7, 0, 0, 32'hDEADBEEF, "lw");
    access(1, 0, 3'b000, 32'h103, 32'd0, 5'd9, 2, 3, 32'h80FF_FFFF, "lb");
    access(1, 0, 3'b100, 32'h103, 32'd0, 5'd9, 2, 3, 32'h80FF_FFFF, "lbu");
    access(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 5'd0, 1, 1, 32'd0, "sh");
    access(1, 0, 3'b101, 32'h002, 32'd0, 5'd11, 0, 2, 32'h9876_5432, "lhu");
    access(1, 1, 3'b000, 32'h011, 32'h0000_00A5, 5'd12, 0, 0, 32'd0, "both");
    access(1, 0, 3'b010, 32'h101, 32'd0, 5'd1, 0, 0, 32'd0, "lw_mis");
    access(0, 1, 3'b001, 32'h203, 32'd0, 5'd0, 0, 0, 32'd0, "sh_mis");
    access(0, 1, 3'b100, 32'h200, 32'd0, 5'd0, 0, 0, 32'd0, "sbu_ill");
    access(1, 0, 3'b011, 32'h200, 32'd0, 5'd2, 0, 0, 32'd0, "f3_ill");
    access(1, 0, 3'b010, 32'h040, 32'd0, 5'd3, 0, 20, 32'd0, "lw_timeout");

    // Reset while waiting for rvalid abandons the access.
    load_en = 1'b1; funct3 = 3'b010; addr = 32'h300; rd = 5'd4;
    next_cycle();
    mem_gnt = 1'b1;
    next_cycle();
    mem_gnt = 1'b0;
    next_cycle();
    load_en = 1'b0;
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstwait:mem_req", mem_req, 0);
    chk("rstwait:stall", stall, 0);
    chk("rstwait:wb_valid", wb_valid, 0);
    chk("rstwait:timeout", timeout_fault, 0);
    next_cycle();
    access(1, 0, 3'b010, 32'h304, 32'd0, 5'd5, 1, 2, 32'hCAFE_F00D, "lw_after_rst");

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      rf3  = 3'($urandom_range(0, 7));
      ra   = $urandom;
      g    = $urandom_range(0, 3);
      rv   = g + $urandom_range(0, 6);
      access(kind != 1, kind != 0, rf3, ra, $urandom, 5'($urandom_range(0, 31)),
             g, rv, $urandom, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
